// File: rtl/adc_serial_sampler.sv
// rtl/adc_serial_sampler.sv - periodic multi-channel serial ADC frame sampler
// Drives a shared chip select, deserialises NUM_CH lines and hands samples out via valid/ready.
module adc_serial_sampler #(
  parameter int NUM_CH        = 1,
  parameter int DATA_BITS     = 12,
  parameter int LEAD_BITS     = 4,
  parameter int SAMPLE_PERIOD = 250000
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             adcData,
  output logic                          CSOut,
  output logic [NUM_CH*DATA_BITS-1:0]   sampleData,
  output logic                          sampleValid,
  input  logic                          sampleReady,
  output logic                          leadErr,
  output logic                          overrun,
  input  logic                          clearOverrun
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
  localparam int PW         = $clog2(SAMPLE_PERIOD);
  localparam int BW         = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                                state_q;
  logic [PW-1:0]                         period_cnt_q, period_cnt_d;
  logic [BW-1:0]                         bit_cnt_q;
  logic [NUM_CH-1:0][FRAME_BITS-1:0]     shift_q, shift_d;
  logic                                  cs_q;
  logic [NUM_CH*DATA_BITS-1:0]           data_q, data_d;
  logic                                  valid_q;
  logic                                  lead_q, lead_d;
  logic                                  overrun_q;

  // The period counter parks at zero while disabled so a re-enable starts a frame on the next edge.
  always_comb begin
    if (state_q == IDLE && period_cnt_q == '0 && !enable) begin
      period_cnt_d = '0;
    end else if (period_cnt_q == PW'(SAMPLE_PERIOD - 1)) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + PW'(1);
    end
  end

  always_comb begin
    shift_d = shift_q;
    data_d  = '0;
    lead_d  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      shift_d[c] = {shift_q[c][FRAME_BITS-2:0], adcData[c]};
      data_d[c*DATA_BITS +: DATA_BITS] = shift_q[c][DATA_BITS-1:0];
      lead_d = lead_d | (|shift_q[c][FRAME_BITS-1:DATA_BITS]);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cs_q         <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      lead_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;

      case (state_q)
        IDLE: begin
          if (period_cnt_q == '0 && enable) begin
            state_q   <= CONV;
            cs_q      <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        CONV: begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
            cs_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // A DONE load always wins over a consume at the same edge.
      if (state_q == DONE) begin
        data_q  <= data_d;
        lead_q  <= lead_d;
        valid_q <= 1'b1;
      end else if (valid_q && sampleReady) begin
        valid_q <= 1'b0;
      end

      if (state_q == DONE && valid_q && !sampleReady) begin
        overrun_q <= 1'b1;
      end else if (clearOverrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign CSOut       = cs_q;
  assign sampleData  = data_q;
  assign sampleValid = valid_q;
  assign leadErr     = lead_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_serial_sampler.sv
// tb/tb_adc_serial_sampler.sv - self-checking bench for adc_serial_sampler
// A behavioural ADC feeds queued 32-bit frames {ch1,ch0}; expectations come from an arithmetic model.
module tb_adc_serial_sampler;

  localparam int NUM_CH        = 2;
  localparam int DATA_BITS     = 12;
  localparam int LEAD_BITS     = 4;
  localparam int SAMPLE_PERIOD = 40;

  logic                        clk = 1'b0;
  logic                        rstN = 1'b0;
  logic                        enable = 1'b1;
  logic [NUM_CH-1:0]           adcData = '0;
  logic                        CSOut;
  logic [NUM_CH*DATA_BITS-1:0] sampleData;
  logic                        sampleValid;
  logic                        sampleReady = 1'b1;
  logic                        leadErr;
  logic                        overrun;
  logic                        clearOverrun = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] frame_q[$];
  logic [31:0] cur_frame  = '0;
  logic [31:0] last_frame = '0;
  int          bit_idx    = 0;

  adc_serial_sampler #(
    .NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS), .LEAD_BITS(LEAD_BITS), .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .adcData(adcData), .CSOut(CSOut),
    .sampleData(sampleData), .sampleValid(sampleValid), .sampleReady(sampleReady),
    .leadErr(leadErr), .overrun(overrun), .clearOverrun(clearOverrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC pin model: while selected, present the next frame bit MSB first after each falling clock edge.
  always @(negedge clk) begin
    if (CSOut !== 1'b0) begin
      bit_idx = 0;
      adcData = 2'($urandom);
    end else begin
      if (bit_idx == 0) begin
        if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
        else cur_frame = $urandom;
        last_frame = cur_frame;
      end
      if (bit_idx < 16) begin
        adcData[0] = cur_frame[15 - bit_idx];
        adcData[1] = cur_frame[31 - bit_idx];
      end
      bit_idx++;
    end
  end

  function automatic void model(input logic [31:0] f, output logic [23:0] d, output logic l);
    int ch0, ch1;
    ch0 = int'(f % 65536);
    ch1 = int'(f / 65536);
    d = 24'((ch1 % 4096) * 4096 + (ch0 % 4096));
    l = (ch0 / 4096 != 0) || (ch1 / 4096 != 0);
  endfunction

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sampleValid === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_valid_timeout: sampleValid never rose, want 1", name); end
  endtask

  task automatic wait_cs_fall(input string name);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (CSOut === 1'b0) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_cs_timeout: CSOut never fell, want 0", name); end
  endtask

  task automatic idle_gap();
    enable = 1'b0;
    repeat (45) @(negedge clk);
  endtask

  task automatic test_reset();
    int low;
    rstN = 1'b0; enable = 1'b1; sampleReady = 1'b1;
    frame_q.push_back({16'h0FFF, 16'h0A5C});
    repeat (3) @(negedge clk);
    n_cmp++; if (CSOut !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", CSOut); end
    n_cmp++; if (sampleValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sampleValid); end
    n_cmp++; if (sampleData !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", sampleData); end
    n_cmp++; if (leadErr !== 1'b0) begin n_fail++; $display("FAIL reset_lead: got %b want 0", leadErr); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rstN = 1'b1;
    @(negedge clk);
    n_cmp++; if (CSOut !== 1'b0) begin n_fail++; $display("FAIL first_fall: got %b want 0", CSOut); end
    enable = 1'b0;
    low = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (CSOut !== 1'b0) break;
      low++;
    end
    n_cmp++; if (low != 16) begin n_fail++; $display("FAIL cs_low_len: got %0d want 16", low); end
    n_cmp++; if (sampleValid !== 1'b0) begin n_fail++; $display("FAIL valid_at_rise: got %b want 0", sampleValid); end
    @(negedge clk);
    n_cmp++; if (sampleValid !== 1'b1) begin n_fail++; $display("FAIL valid_latency: got %b want 1", sampleValid); end
    n_cmp++; if (sampleData !== 24'hFFFA5C) begin n_fail++; $display("FAIL first_data: got %h want fffa5c", sampleData); end
    n_cmp++; if (leadErr !== 1'b0) begin n_fail++; $display("FAIL first_lead: got %b want 0", leadErr); end
    idle_gap();
  endtask

  task automatic test_lead_err();
    logic [15:0] ch0;
    ch0 = 16'($urandom_range(0, 4095));
    frame_q.push_back({16'h8123, ch0});
    enable = 1'b1; @(negedge clk); enable = 1'b0;
    wait_valid("lead");
    n_cmp++; if (leadErr !== 1'b1) begin n_fail++; $display("FAIL lead_flag: got %b want 1", leadErr); end
    n_cmp++; if (sampleData[23:12] !== 12'h123) begin n_fail++; $display("FAIL lead_ch1: got %h want 123", sampleData[23:12]); end
    n_cmp++; if (sampleData[11:0] !== ch0[11:0]) begin n_fail++; $display("FAIL lead_ch0: got %h want %h", sampleData[11:0], ch0[11:0]); end
    idle_gap();
  endtask

  task automatic test_random_frames();
    logic [31:0] f;
    logic [23:0] d;
    logic l;
    for (int i = 0; i < 6; i++) begin
      f = $urandom;
      if ($urandom_range(0, 1) == 1) f = f & 32'h0FFF0FFF;
      model(f, d, l);
      frame_q.push_back(f);
      enable = 1'b1; @(negedge clk); enable = 1'b0;
      wait_valid("rand");
      n_cmp++; if (sampleData !== d) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, sampleData, d); end
      n_cmp++; if (leadErr !== l) begin n_fail++; $display("FAIL rand_lead[%0d]: got %b want %b", i, leadErr, l); end
      idle_gap();
    end
  endtask

  task automatic test_overrun();
    logic [31:0] f1, f2;
    logic [23:0] d1, d2;
    logic l1, l2;
    bit ok = 0;
    f1 = $urandom; f2 = $urandom;
    model(f1, d1, l1); model(f2, d2, l2);
    sampleReady = 1'b0;
    frame_q.push_back(f1); frame_q.push_back(f2);
    enable = 1'b1;
    wait_valid("ovr");
    n_cmp++; if (sampleData !== d1) begin n_fail++; $display("FAIL ovr_data1: got %h want %h", sampleData, d1); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", overrun); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) begin ok = 1; break; end
    end
    enable = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovr_set: overrun never rose, want 1"); end
    n_cmp++; if (sampleValid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", sampleValid); end
    n_cmp++; if (sampleData !== d2) begin n_fail++; $display("FAIL ovr_data2: got %h want %h", sampleData, d2); end
    n_cmp++; if (leadErr !== l2) begin n_fail++; $display("FAIL ovr_lead2: got %b want %b", leadErr, l2); end
    clearOverrun = 1'b1; @(negedge clk); clearOverrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    n_cmp++; if (sampleValid !== 1'b1) begin n_fail++; $display("FAIL ovr_clear_valid: got %b want 1", sampleValid); end
    sampleReady = 1'b1; @(negedge clk);
    n_cmp++; if (sampleValid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume: got %b want 0", sampleValid); end
    idle_gap();
  endtask

  task automatic test_back_to_back();
    logic [31:0] f1, f2;
    logic [23:0] d1, d2;
    logic l1, l2;
    f1 = $urandom; f2 = $urandom;
    model(f1, d1, l1); model(f2, d2, l2);
    sampleReady = 1'b0;
    frame_q.push_back(f1); frame_q.push_back(f2);
    enable = 1'b1;
    wait_valid("b2b");
    n_cmp++; if (sampleData !== d1) begin n_fail++; $display("FAIL b2b_data1: got %h want %h", sampleData, d1); end
    wait_cs_fall("b2b");
    enable = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++; if (sampleValid !== 1'b1 || sampleData !== d1) begin
      n_fail++; $display("FAIL b2b_hold: got v=%b %h want v=1 %h", sampleValid, sampleData, d1);
    end
    sampleReady = 1'b1; @(negedge clk); sampleReady = 1'b0;
    n_cmp++; if (sampleValid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", sampleValid); end
    n_cmp++; if (sampleData !== d2) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", sampleData, d2); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    sampleReady = 1'b1; @(negedge clk);
    n_cmp++; if (sampleValid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume: got %b want 0", sampleValid); end
    idle_gap();
  endtask

  task automatic test_period();
    int falls[$];
    int extra = 0;
    logic prev = 1'b1;
    logic [31:0] f;
    logic [23:0] d;
    logic l;
    sampleReady = 1'b1; enable = 1'b1;
    for (int i = 0; i < 400 && falls.size() < 8; i++) begin
      @(negedge clk);
      if (CSOut === 1'b0 && prev === 1'b1) falls.push_back(cyc);
      prev = CSOut;
    end
    repeat (5) @(negedge clk);
    enable = 1'b0;
    f = last_frame;
    model(f, d, l);
    n_cmp++; if (falls.size() != 8) begin n_fail++; $display("FAIL period_count: got %0d want 8", falls.size()); end
    for (int i = 1; i < falls.size(); i++) begin
      n_cmp++; if (falls[i] - falls[i-1] != SAMPLE_PERIOD) begin
        n_fail++; $display("FAIL period_gap[%0d]: got %0d want %0d", i, falls[i] - falls[i-1], SAMPLE_PERIOD);
      end
    end
    wait_valid("period");
    n_cmp++; if (sampleData !== d || leadErr !== l) begin
      n_fail++; $display("FAIL period_last_data: got %h/%b want %h/%b", sampleData, leadErr, d, l);
    end
    prev = CSOut;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (CSOut === 1'b0 && prev === 1'b1) extra++;
      prev = CSOut;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL period_stop: got %0d falls want 0", extra); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] f1, f3;
    logic [23:0] d3;
    logic l3;
    f1 = $urandom; f3 = $urandom;
    model(f3, d3, l3);
    sampleReady = 1'b0;
    frame_q.push_back(f1);
    enable = 1'b1; @(negedge clk); enable = 1'b0;
    wait_valid("rstmid_pre");
    idle_gap();
    frame_q.push_back($urandom); frame_q.push_back(f3);
    enable = 1'b1; @(negedge clk);
    repeat (7) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    n_cmp++; if (CSOut !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs: got %b want 1", CSOut); end
    n_cmp++; if (sampleValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", sampleValid); end
    n_cmp++; if (sampleData !== 24'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", sampleData); end
    @(negedge clk);
    rstN = 1'b1; sampleReady = 1'b1;
    @(negedge clk);
    n_cmp++; if (CSOut !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart: got %b want 0", CSOut); end
    enable = 1'b0;
    wait_valid("rstmid");
    n_cmp++; if (sampleData !== d3) begin n_fail++; $display("FAIL rstmid_data3: got %h want %h", sampleData, d3); end
    n_cmp++; if (leadErr !== l3) begin n_fail++; $display("FAIL rstmid_lead3: got %b want %b", leadErr, l3); end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_lead_err();
    test_random_frames();
    test_overrun();
    test_back_to_back();
    test_period();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
